// File: rtl/otter_icache_pkg.sv
// otter_icache_pkg: shared types and address-split width helpers for the
// OTTER direct-mapped instruction cache.
package otter_icache_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // word-offset field width
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    // line-index field width
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // tag width: whatever remains of the word address above index and offset
    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/otter_icache_if.sv
// otter_icache_if: fetch-side and main-memory-side signals of the cache.
// The slave modport is the cache's view; master is the CU/memory side.
interface otter_icache_if;
    logic        IC_RD;
    logic [31:0] IC_ADDR;
    logic        IC_FLUSH;
    logic [31:0] IC_DOUT;
    logic        IC_VALID;
    logic        IC_MEM_RD;
    logic [31:0] IC_MEM_ADDR;
    logic [31:0] IC_MEM_DIN;
    logic        IC_MEM_ACK;

    modport slave (
        input  IC_RD, IC_ADDR, IC_FLUSH, IC_MEM_DIN, IC_MEM_ACK,
        output IC_DOUT, IC_VALID, IC_MEM_RD, IC_MEM_ADDR
    );

    modport master (
        output IC_RD, IC_ADDR, IC_FLUSH, IC_MEM_DIN, IC_MEM_ACK,
        input  IC_DOUT, IC_VALID, IC_MEM_RD, IC_MEM_ADDR
    );
endinterface

// File: rtl/otter_icache_line_store.sv
// icache_line_store: valid/tag/data arrays of the instruction cache.
// One combinational read port, one word-write port, set-valid and
// clear-all-valid controls. Only the valid bits are reset.
module icache_line_store
    import otter_icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 8,
    localparam int OFF_W = off_w(WORDS),
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(LINES, WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_vld,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             set_vld,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_all
);

    logic [LINES-1:0] vld;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][WORDS];

    assign rd_vld  = vld[rd_idx];
    assign rd_tag  = tags[rd_idx];
    assign rd_data = data[rd_idx][rd_off];

    // valid bits: clear-all wins over set so a flushed fill never goes live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld <= '0;
        else if (clr_all)
            vld <= '0;
        else if (set_vld)
            vld[set_idx] <= 1'b1;
    end

    // data and tag arrays carry no reset; the valid bit guards them
    always_ff @(posedge clk) begin
        if (wr_en)
            data[wr_idx][wr_off] <= wr_data;
        if (set_vld)
            tags[set_idx] <= set_tag;
    end

endmodule

// File: rtl/otter_icache.sv
// otter_icache: direct-mapped read-only instruction cache for the OTTER
// multicycle CPU. Hits answer combinationally; misses fill a whole line
// word by word from main memory, then the held request hits.
// Optional feature macro: ICACHE_PERF_EN adds IC_HITS / IC_MISSES counters.
module otter_icache
    import otter_icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 8
) (
    input  logic          IC_CLK,
    input  logic          IC_RST_N,
    otter_icache_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]   IC_HITS,
    output logic [31:0]   IC_MISSES
`endif
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, WORDS);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_FILL = FILL;

    logic [0:0]       state;
    logic [TAG_W-1:0] lat_tag;
    logic [IDX_W-1:0] lat_idx;
    logic [OFF_W-1:0] cnt;
    logic             flush_pend;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             rd_vld;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit, miss, fill_ack, last_ack, flush_now;
    logic             addr_unused;

    assign req_tag     = bus.IC_ADDR[31:OFF_W+IDX_W+2];
    assign req_idx     = bus.IC_ADDR[OFF_W+IDX_W+1:OFF_W+2];
    assign req_off     = bus.IC_ADDR[OFF_W+1:2];
    assign addr_unused = &{1'b0, bus.IC_ADDR[1:0]};

    assign hit       = bus.IC_RD && (state == S_IDLE) && rd_vld && (rd_tag == req_tag);
    assign miss      = bus.IC_RD && (state == S_IDLE) && !hit;
    assign fill_ack  = (state == S_FILL) && bus.IC_MEM_ACK;
    assign last_ack  = fill_ack && (cnt == OFF_W'(WORDS - 1));
    assign flush_now = flush_pend || bus.IC_FLUSH;

    icache_line_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
        .clk     (IC_CLK),
        .rst_n   (IC_RST_N),
        .rd_idx  (req_idx),
        .rd_off  (req_off),
        .rd_vld  (rd_vld),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (fill_ack),
        .wr_idx  (lat_idx),
        .wr_off  (cnt),
        .wr_data (bus.IC_MEM_DIN),
        .set_vld (last_ack && !flush_now),
        .set_idx (lat_idx),
        .set_tag (lat_tag),
        .clr_all (((state == S_IDLE) && bus.IC_FLUSH) || (last_ack && flush_now))
    );

    assign bus.IC_VALID    = hit;
    assign bus.IC_DOUT     = hit ? rd_data : 32'h0;
    assign bus.IC_MEM_RD   = (state == S_FILL);
    assign bus.IC_MEM_ADDR = (state == S_FILL) ? {lat_tag, lat_idx, cnt, 2'b00} : 32'h0;

    // fetch FSM: latch the missing line, count acks, return to IDLE on the last word
    always_ff @(posedge IC_CLK or negedge IC_RST_N) begin
        if (!IC_RST_N) begin
            state      <= S_IDLE;
            lat_tag    <= '0;
            lat_idx    <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else if (state == S_IDLE) begin
            if (miss) begin
                state   <= S_FILL;
                lat_tag <= req_tag;
                lat_idx <= req_idx;
                cnt     <= '0;
            end
        end else begin
            if (bus.IC_FLUSH)
                flush_pend <= 1'b1;
            if (fill_ack)
                cnt <= cnt + 1'b1;
            if (last_ack) begin
                state      <= S_IDLE;
                flush_pend <= 1'b0;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    // free-running hit/miss counters, wrapping modulo 2^32
    always_ff @(posedge IC_CLK or negedge IC_RST_N) begin
        if (!IC_RST_N) begin
            IC_HITS   <= '0;
            IC_MISSES <= '0;
        end else begin
            if (hit)
                IC_HITS <= IC_HITS + 32'd1;
            if (miss)
                IC_MISSES <= IC_MISSES + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_otter_icache.sv
// tb_otter_icache: table-driven check of otter_icache (LINES=16, WORDS=8)
// with a held-request fetch task acting as CU and main memory, plus
// hand-written flush, stray-ack and mid-fill reset sequences.
module tb_otter_icache;

    logic IC_CLK   = 1'b0;
    logic IC_RST_N = 1'b0;

    otter_icache_if bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] hits, misses;
`endif

    otter_icache #(.LINES(16), .WORDS(8)) dut (
        .IC_CLK   (IC_CLK),
        .IC_RST_N (IC_RST_N),
        .bus      (bus)
`ifdef ICACHE_PERF_EN
        ,
        .IC_HITS  (hits),
        .IC_MISSES(misses)
`endif
    );

    always #5 IC_CLK = ~IC_CLK;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        int          dly;
        int          flush_at;
        int          cyc;
        int          acks;
        int          rdcyc;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // memory contents: distinct per 128-byte block, low bits = word in line
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + ({a[31:7], 7'b0} << 8) + {29'b0, a[4:2]};
    endfunction

    // hold IC_RD until IC_VALID, serving the fill with acks every dly+1 cycles
    task automatic fetch(input logic [31:0] a, input int dly, input int flush_at,
                         output int cyc, output int acks, output int rdcyc,
                         output logic [31:0] dout, output bit addr_ok);
        int          wait_cnt;
        bit          done;
        logic [31:0] ea;
        cyc = 0; acks = 0; rdcyc = 0; dout = '0; addr_ok = 1'b1;
        wait_cnt = 0; done = 1'b0;
        bus.IC_RD   = 1'b1;
        bus.IC_ADDR = a;
        while (!done && cyc < 300) begin
            bus.IC_MEM_ACK = 1'b0;
            bus.IC_FLUSH   = 1'b0;
            bus.IC_MEM_DIN = 32'hDEAD_BEEF;
            if (bus.IC_MEM_RD) begin
                rdcyc++;
                ea = {a[31:5], 5'b0} | (32'(acks % 8) << 2);
                if (bus.IC_MEM_ADDR !== ea) addr_ok = 1'b0;
                if (wait_cnt == dly) begin
                    bus.IC_MEM_ACK = 1'b1;
                    bus.IC_MEM_DIN = mem_word(bus.IC_MEM_ADDR);
                    acks++;
                    wait_cnt = 0;
                    if (acks == flush_at) bus.IC_FLUSH = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge IC_CLK);
            if (bus.IC_VALID) begin
                if (bus.IC_MEM_RD) addr_ok = 1'b0;
                dout = bus.IC_DOUT;
                done = 1'b1;
            end
            @(posedge IC_CLK); #1;
            if (!done) cyc++;
        end
        bus.IC_RD      = 1'b0;
        bus.IC_MEM_ACK = 1'b0;
        bus.IC_FLUSH   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, acks, rdcyc, k, na;
        logic [31:0] dout;
        bit          aok;
`ifdef ICACHE_PERF_EN
        logic [31:0] h0, m0;
`endif

        //            addr          dly fl  cyc acks rdcyc dout
        vecs[0]  = '{32'h0000_0040, 0, 0,  9,  8,  8, 32'h1000_0000};  // cold miss
        vecs[1]  = '{32'h0000_0048, 0, 0,  0,  0,  0, 32'h1000_0002};  // hit
        vecs[2]  = '{32'h0000_005C, 0, 0,  0,  0,  0, 32'h1000_0007};  // hit, last word
        vecs[3]  = '{32'h0000_00E0, 0, 0,  9,  8,  8, 32'h1000_8000};  // other line
        vecs[4]  = '{32'h0000_0240, 0, 0,  9,  8,  8, 32'h1002_0000};  // conflict
        vecs[5]  = '{32'h0000_0040, 0, 0,  9,  8,  8, 32'h1000_0000};  // evicted, refill
        vecs[6]  = '{32'h0000_0244, 0, 0,  9,  8,  8, 32'h1002_0001};  // evicted again
        vecs[7]  = '{32'h0000_0040, 0, 3, 18, 16, 16, 32'h1000_0000};  // flush mid-fill
        vecs[8]  = '{32'h0000_0040, 0, 0,  0,  0,  0, 32'h1000_0000};  // hit after refill
        vecs[9]  = '{32'h0000_00E4, 0, 0,  9,  8,  8, 32'h1000_8001};  // flushed line
        vecs[10] = '{32'h0000_03A8, 3, 0, 33,  8, 32, 32'h1003_8002};  // ack stall
        vecs[11] = '{32'h0000_03A0, 0, 0,  0,  0,  0, 32'h1003_8000};  // hit

        bus.IC_RD = 1'b0; bus.IC_ADDR = '0; bus.IC_FLUSH = 1'b0;
        bus.IC_MEM_DIN = '0; bus.IC_MEM_ACK = 1'b0;

        #12;
        chk("reset VALID",    32'(bus.IC_VALID),  32'h0);
        chk("reset DOUT",     bus.IC_DOUT,        32'h0);
        chk("reset MEM_RD",   32'(bus.IC_MEM_RD), 32'h0);
        chk("reset MEM_ADDR", bus.IC_MEM_ADDR,    32'h0);
        @(negedge IC_CLK);
        IC_RST_N = 1'b1;
        @(posedge IC_CLK); #1;

        for (int i = 0; i < 12; i++) begin
`ifdef ICACHE_PERF_EN
            h0 = hits; m0 = misses;
`endif
            fetch(vecs[i].addr, vecs[i].dly, vecs[i].flush_at, cyc, acks, rdcyc, dout, aok);
            chk($sformatf("v%0d latency", i),  32'(cyc),   32'(vecs[i].cyc));
            chk($sformatf("v%0d acks", i),     32'(acks),  32'(vecs[i].acks));
            chk($sformatf("v%0d memrd_cycles", i), 32'(rdcyc), 32'(vecs[i].rdcyc));
            chk($sformatf("v%0d dout", i),     dout,       vecs[i].dout);
            chk($sformatf("v%0d fill_addr_ok", i), 32'(aok), 32'h1);
`ifdef ICACHE_PERF_EN
            if (i == 10) begin
                chk("perf misses delta", misses - m0, 32'd1);
                chk("perf hits delta",   hits - h0,   32'd1);
            end
`endif
        end

        // flush in the same cycle as a hit still returns the hit
        bus.IC_RD = 1'b1; bus.IC_ADDR = 32'h0000_03A4; bus.IC_FLUSH = 1'b1;
        @(negedge IC_CLK);
        chk("flush+hit VALID", 32'(bus.IC_VALID), 32'h1);
        chk("flush+hit DOUT",  bus.IC_DOUT,       32'h1003_8001);
        @(posedge IC_CLK); #1;
        bus.IC_RD = 1'b0; bus.IC_FLUSH = 1'b0;
        fetch(32'h0000_03A4, 0, 0, cyc, acks, rdcyc, dout, aok);
        chk("post-flush latency", 32'(cyc), 32'd9);
        chk("post-flush dout",    dout,     32'h1003_8001);

        // stray acks while idle must not touch the array
        bus.IC_MEM_ACK = 1'b1; bus.IC_MEM_DIN = 32'hBAD0_0BAD;
        repeat (2) @(posedge IC_CLK);
        #1;
        bus.IC_MEM_ACK = 1'b0;
        chk("stray ack MEM_RD", 32'(bus.IC_MEM_RD), 32'h0);
        fetch(32'h0000_03A8, 0, 0, cyc, acks, rdcyc, dout, aok);
        chk("stray ack latency", 32'(cyc), 32'd0);
        chk("stray ack dout",    dout,     32'h1003_8002);

        // asynchronous reset after the fourth ack of a fill
        bus.IC_RD = 1'b1; bus.IC_ADDR = 32'h0000_00C0;
        k = 0; na = 0;
        while (na < 4 && k < 20) begin
            bus.IC_MEM_ACK = bus.IC_MEM_RD;
            bus.IC_MEM_DIN = mem_word(bus.IC_MEM_ADDR);
            if (bus.IC_MEM_RD) na++;
            @(posedge IC_CLK); #1;
            k++;
        end
        bus.IC_MEM_ACK = 1'b0;
        chk("pre-reset acks",     32'(na),             32'd4);
        chk("pre-reset MEM_RD",   32'(bus.IC_MEM_RD),  32'h1);
        chk("pre-reset MEM_ADDR", bus.IC_MEM_ADDR,     32'h0000_00D0);
        #1 IC_RST_N = 1'b0;
        #1;
        chk("async reset MEM_RD",   32'(bus.IC_MEM_RD), 32'h0);
        chk("async reset MEM_ADDR", bus.IC_MEM_ADDR,    32'h0);
        chk("async reset VALID",    32'(bus.IC_VALID),  32'h0);
        bus.IC_RD = 1'b0;
        @(negedge IC_CLK);
        IC_RST_N = 1'b1;
        @(posedge IC_CLK); #1;
        fetch(32'h0000_00C0, 0, 0, cyc, acks, rdcyc, dout, aok);
        chk("refill latency", 32'(cyc), 32'd9);
        chk("refill acks",    32'(acks), 32'd8);
        chk("refill addr_ok", 32'(aok), 32'h1);
        chk("refill dout",    dout,     32'h1000_8000);
        fetch(32'h0000_03A8, 0, 0, cyc, acks, rdcyc, dout, aok);
        chk("reset cleared valid", 32'(cyc), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_icache.md
# otter_icache

Direct-mapped, read-only instruction cache between the OTTER multicycle control FSM's fetch port and main memory. Accepts the FETCH-state read request and PC, answers hits in the same cycle, and on a miss fills the whole line from main memory with a sequential word-by-word handshake. Its `IC_VALID` output is the control FSM's fetch-valid input (`MEM_VALID1`), which holds the FSM in FETCH until asserted.

## Interface
- `LINES`, 16 — number of cache lines; power of two, at least 2.
- `WORDS`, 8 — 32-bit words per line; power of two, at least 2.
- `IC_CLK` in 1 — clock; all state updates on the rising edge.
- `IC_RST_N` in 1 — reset, asynchronous, active-low.
- `IC_RD` in 1 — fetch request; connected to the CU's `MEMREAD1`.
- `IC_ADDR` in 32 — PC; bits [1:0] are ignored.
- `IC_FLUSH` in 1 — one-cycle pulse that invalidates all lines (fence.i).
- `IC_DOUT` out 32 — fetched instruction; 0 when `IC_VALID` is low.
- `IC_VALID` out 1 — hit indication; connected to the CU's `MEM_VALID1`.
- `IC_MEM_RD` out 1 — main-memory read request.
- `IC_MEM_ADDR` out 32 — word-aligned fill address.
- `IC_MEM_DIN` in 32 — main-memory read data.
- `IC_MEM_ACK` in 1 — read-data-valid strobe from main memory.

## Operation
- Address split:
  - OFF = log2(`WORDS`), taken from `IC_ADDR[OFF+1:2]`.
  - IDX = log2(`LINES`), taken from the next IDX bits.
  - TAG is the remaining upper bits.
- Per line: valid bit, tag, and `WORDS` data words, all in flops.
- **IDLE**
  - Hit = `IC_RD` and the line at IDX is valid and its tag matches.
  - On a hit, `IC_VALID` and `IC_DOUT` are driven combinationally in the same cycle.
  - On `IC_RD` with a miss: latch TAG and IDX, clear the word counter, go to FILL.
- **FILL**
  - `IC_MEM_RD`=1.
  - `IC_MEM_ADDR` = {latched TAG, latched IDX, counter, 2'b00}.
  - On each `IC_MEM_ACK`, write `IC_MEM_DIN` into the word at the counter and increment the counter.
  - On the ack for word `WORDS`-1: write the tag, set the valid bit, go to IDLE.
  - The retry then hits.
  - `IC_VALID`=0 throughout FILL.
- `IC_RD` dropping or `IC_ADDR` changing during FILL has no effect; the fill always completes on the latched address.
- **Flush**
  - `IC_FLUSH` in IDLE clears all valid bits at the next edge.
  - `IC_FLUSH` in the same cycle as a hit still returns that hit.
  - `IC_FLUSH` during FILL is recorded in a pending flag. When the fill completes, all valid bits are cleared and the filled line is not marked valid.
- **Reset** (async, anytime, including mid-fill):
  - State=IDLE, all valid bits=0, counter=0, pending flush=0.
  - `IC_MEM_RD`=0, `IC_MEM_ADDR`=0, `IC_VALID`=0, `IC_DOUT`=0.
  - Data and tag arrays are not reset.
- An `IC_MEM_ACK` seen outside FILL is ignored.

## Timing
- Hit latency: 0 cycles. `IC_VALID` rises in the cycle `IC_RD` is sampled high; the CU leaves FETCH on that edge.
- Miss latency:
  - 1 cycle IDLE→FILL.
  - Then `WORDS` acks, each at least 1 cycle.
  - Then 1 hit cycle.
  - With single-cycle acks and `WORDS`=8: `IC_VALID` rises in cycle 9 after the request cycle.
- `IC_MEM_RD` is held high continuously from the first FILL cycle through the cycle of the last ack.
- The address advances the cycle after each ack.
- Back-to-back acks are legal: one word per cycle.

## Configuration
- `ICACHE_PERF_EN` defined: adds outputs `IC_HITS` and `IC_MISSES`, each 32 bits.
  - Both reset to 0 and wrap modulo 2^32.
  - `IC_HITS` increments on each cycle with `IC_VALID`=1.
  - `IC_MISSES` increments on each IDLE→FILL transition.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `otter_icache_pkg`:
  - state enum `icache_state_t` {IDLE, FILL};
  - helper functions that derive OFF, IDX and TAG widths from `LINES` and `WORDS`.
- Sub-module `icache_line_store`: the valid/tag/data arrays, with one read port (IDX, OFF) and one word-write port. It also provides set-valid and clear-all-valid controls.
- The top level holds the FSM, the latches, the counter and the flush-pending flag.

## Test plan
- Cold miss:
  - Stimulus: after reset, `IC_RD`=1, `IC_ADDR`=0x00000040, memory returns 0x1000_0000+word index with 1-cycle ack.
  - Expect: `IC_MEM_ADDR` steps 0x40..0x5C; `IC_VALID` in cycle 9; `IC_DOUT`=0x1000_0000.
- Hit:
  - Stimulus: follow the cold miss with `IC_ADDR`=0x00000048.
  - Expect: `IC_VALID`=1 in the same cycle, `IC_DOUT`=0x1000_0002, `IC_MEM_RD` stays 0.
- Conflict eviction, `LINES`=16, `WORDS`=8:
  - Stimulus: fetch 0x040, then 0x240 (same index, new tag), then 0x040.
  - Expect: three full fills, 24 acks total.
- Flush during fill:
  - Stimulus: pulse `IC_FLUSH` at the third ack of the fill for 0x040, then refetch 0x040.
  - Expect: the fill completes, then the refetch misses again.
- Reset mid-fill:
  - Stimulus: drop `IC_RST_N` after the fourth ack.
  - Expect: `IC_MEM_RD`=0 immediately (asynchronously); the next fetch of the same line misses and refills from word 0.
- Ack stall:
  - Stimulus: memory delays each ack by 3 cycles.
  - Expect: `IC_MEM_RD` and `IC_MEM_ADDR` held stable between acks; data correct; with `ICACHE_PERF_EN`, `IC_MISSES`=1 and `IC_HITS`=1.
